// File: rtl/pdes_event_ctrl.sv
// pdes_event_ctrl
// Run sequencer for the PHOLD PDES engine. It takes a run from start
// through initial-event seeding into the running phase and on to
// completion. While running, it moves new events from the cores into the
// external priority queue, dispatches queue-head events to ready cores and
// keeps a monotonic global virtual time (GVT).
module pdes_event_ctrl #(
  parameter int NUM_CORE     = 4,
  parameter int NB_COREID    = 2,
  parameter int NUM_LP       = 16,
  parameter int NB_LPID      = 4,
  parameter int TIME_WID     = 16,
  parameter int MSG_WID      = 32,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [TIME_WID-1:0]          sim_end_time,
  output logic [TIME_WID-1:0]          gvt,
  output logic                         rtn_vld,
  output logic                         busy,
  input  logic [NUM_CORE-1:0]          core_out_vld,
  input  logic [NUM_CORE*MSG_WID-1:0]  core_out_msg,
  output logic [NUM_CORE-1:0]          core_out_ack,
  input  logic [NUM_CORE-1:0]          core_ready,
  output logic [NUM_CORE-1:0]          core_evt_vld,
  output logic [MSG_WID-1:0]           core_evt_msg,
  input  logic [TIME_WID-1:0]          min_time,
  input  logic                         min_time_vld,
  output logic                         q_enq,
  output logic [MSG_WID-1:0]           q_enq_data,
  output logic                         q_deq,
  input  logic [MSG_WID-1:0]           q_head,
  input  logic                         q_empty,
  input  logic                         q_full,
  output logic                         rnd_next
);

  localparam int QC_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [NB_LPID-1:0]    init_cnt_q, init_cnt_d;
  logic [NB_COREID-1:0]  rcv_ptr_q, rcv_ptr_d;
  logic [NB_COREID-1:0]  send_ptr_q, send_ptr_d;
  logic [QC_W-1:0]       quiet_cnt_q, quiet_cnt_d;
  logic [TIME_WID-1:0]   gvt_q, gvt_d;
  logic                  busy_q;
  logic                  rtn_vld_q;

  logic [NB_COREID-1:0]  rcv_win;
  logic [NB_COREID-1:0]  snd_win;
  logic [MSG_WID-1:0]    rcv_msg;
  logic [TIME_WID-1:0]   head_time;
  logic [TIME_WID-1:0]   cand;
  logic                  cand_vld;
  logic                  quiet_now;

  // Round-robin pick: lowest requesting index at or after ptr, wrapping.
  function automatic logic [NB_COREID-1:0] rr_pick(
    input logic [NUM_CORE-1:0]  req,
    input logic [NB_COREID-1:0] ptr
  );
    logic [NB_COREID-1:0] win;
    logic                 found;
    int                   idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_CORE; i++) begin
      idx = (int'(ptr) + i) % NUM_CORE;
      if (!found && req[idx]) begin
        win   = idx[NB_COREID-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Pointer following a grant, wrapping at NUM_CORE.
  function automatic logic [NB_COREID-1:0] ptr_inc(input logic [NB_COREID-1:0] w);
    logic [NB_COREID-1:0] r;
    if (w == NB_COREID'(NUM_CORE - 1)) begin
      r = '0;
    end else begin
      r = w + NB_COREID'(1);
    end
    return r;
  endfunction

  // One-hot strobe vector for a core index.
  function automatic logic [NUM_CORE-1:0] onehot(input logic [NB_COREID-1:0] w);
    logic [NUM_CORE-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // A null message (anti=1, lp=0, time=0) is acknowledged but never queued.
  function automatic logic is_null(input logic [MSG_WID-1:0] m);
    return m[TIME_WID+NB_LPID] && (m[TIME_WID +: NB_LPID] == '0) &&
           (m[TIME_WID-1:0] == '0);
  endfunction

  assign rcv_win      = rr_pick(core_out_vld, rcv_ptr_q);
  assign snd_win      = rr_pick(core_ready, send_ptr_q);
  assign rcv_msg      = core_out_msg[rcv_win*MSG_WID +: MSG_WID];
  assign head_time    = q_head[TIME_WID-1:0];
  assign quiet_now    = q_empty && !min_time_vld && (core_out_vld == '0);
  assign core_evt_msg = q_head;
  assign gvt          = gvt_q;
  assign busy         = busy_q;
  assign rtn_vld      = rtn_vld_q;

  // GVT candidate: minimum of the in-flight core time and the queue-head time.
  always_comb begin
    cand_vld = min_time_vld || !q_empty;
    cand     = head_time;
    if (min_time_vld && !q_empty) begin
      cand = (min_time < head_time) ? min_time : head_time;
    end else if (min_time_vld) begin
      cand = min_time;
    end else begin
      cand = head_time;
    end
  end

  // Next-state, arbitration and strobe generation.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rcv_ptr_d    = rcv_ptr_q;
    send_ptr_d   = send_ptr_q;
    quiet_cnt_d  = '0;
    gvt_d        = gvt_q;
    core_out_ack = '0;
    core_evt_vld = '0;
    q_enq        = 1'b0;
    q_enq_data   = '0;
    q_deq        = 1'b0;
    rnd_next     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_INIT;
          gvt_d      = '0;
          init_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_INIT: begin
        if (!q_full) begin
          q_enq                          = 1'b1;
          rnd_next                       = 1'b1;
          q_enq_data[TIME_WID +: NB_LPID] = init_cnt_q;
          init_cnt_d                     = init_cnt_q + NB_LPID'(1);
          if (init_cnt_q == NB_LPID'(NUM_LP - 1)) begin
            state_d = S_RUN;
          end else begin
            state_d = S_INIT;
          end
        end else begin
          state_d = S_INIT;
        end
        if (abort) begin
          state_d = S_FIN;
        end else begin
          state_d = state_d;
        end
      end

      S_RUN: begin
        // Receiving has priority; at most one queue operation per cycle.
        if ((core_out_vld != '0) && !q_full) begin
          core_out_ack = onehot(rcv_win);
          rcv_ptr_d    = ptr_inc(rcv_win);
          if (!is_null(rcv_msg)) begin
            q_enq      = 1'b1;
            q_enq_data = rcv_msg;
          end else begin
            q_enq = 1'b0;
          end
        end else if (!q_empty && (core_ready != '0)) begin
          q_deq        = 1'b1;
          rnd_next     = 1'b1;
          core_evt_vld = onehot(snd_win);
          send_ptr_d   = ptr_inc(snd_win);
        end else begin
          q_enq = 1'b0;
        end

        // GVT only ever moves forward.
        if (cand_vld && (cand > gvt_q)) begin
          gvt_d = cand;
        end else begin
          gvt_d = gvt_q;
        end

        if (quiet_now) begin
          quiet_cnt_d = quiet_cnt_q + QC_W'(1);
        end else begin
          quiet_cnt_d = '0;
        end

        if (abort || (gvt_q > sim_end_time) || (quiet_cnt_d == QC_W'(IDLE_TIMEOUT))) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, pointers, GVT and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      init_cnt_q  <= '0;
      rcv_ptr_q   <= '0;
      send_ptr_q  <= '0;
      quiet_cnt_q <= '0;
      gvt_q       <= '0;
      busy_q      <= 1'b0;
      rtn_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rcv_ptr_q   <= rcv_ptr_d;
      send_ptr_q  <= send_ptr_d;
      quiet_cnt_q <= quiet_cnt_d;
      gvt_q       <= gvt_d;
      busy_q      <= (state_d != S_IDLE);
      rtn_vld_q   <= (state_d == S_FIN);
    end
  end

endmodule
